// File: rtl/mouse_uart_packet_rx.sv
// Host-side decoder for the 6-byte mouse packet stream (AA, XL, XH, YL, YH, BTN)
// arriving from the uart rx handshake. It hunts for sync, checks reserved bits,
// enforces an inter-byte timeout and commits whole packets with a valid pulse.
module mouse_uart_packet_rx #(
    parameter int unsigned FREQ_HZ       = 27000000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_avail,
    input  logic       rx_error,
    output logic       rx_ack,
    output logic [8:0] mouse_x,
    output logic [8:0] mouse_y,
    output logic [2:0] buttons,
    output logic       packet_valid,
    output logic       sync_error,
    output logic       format_error,
    output logic       timeout_error,
    output logic [7:0] err_count
);

    // Timeout length in clock cycles, computed in 64 bits to avoid overflow.
    localparam longint unsigned TIMEOUT_CYCLES_L =
        64'(TIMEOUT_BYTES) * 64'd10 * 64'(FREQ_HZ) / 64'(BAUD);
    localparam int unsigned TIMEOUT_CYCLES = 32'(TIMEOUT_CYCLES_L);
    localparam int unsigned CNT_W_RAW      = $clog2(64'(TIMEOUT_CYCLES) + 64'd1);
    localparam int unsigned CNT_W          = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       SYNC_BYTE    = 8'hAA;
    localparam logic [7:0]       ERR_MAX      = 8'hFF;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_XL   = 3'd1,
        ST_XH   = 3'd2,
        ST_YL   = 3'd3,
        ST_YH   = 3'd4,
        ST_BTN  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic             rx_ack_q, rx_ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       xl_q, xl_d;
    logic             xh_q, xh_d;
    logic [7:0]       yl_q, yl_d;
    logic             yh_q, yh_d;
    logic [8:0]       mouse_x_q, mouse_x_d;
    logic [8:0]       mouse_y_q, mouse_y_d;
    logic [2:0]       buttons_q, buttons_d;
    logic             packet_valid_q, packet_valid_d;
    logic             sync_error_q, sync_error_d;
    logic             format_error_q, format_error_d;
    logic             timeout_error_q, timeout_error_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             err_inc;

    logic   accept_c;
    logic   is_sync_c;
    logic   hi_ok_c;
    logic   btn_ok_c;
    logic   timeout_hit_c;
    state_e resync_c;

    // Byte acceptance, reserved-bit checks and timeout expiry detection.
    assign accept_c      = rx_avail && !rx_ack_q;
    assign is_sync_c     = (rx_data == SYNC_BYTE);
    assign hi_ok_c       = (rx_data[7:1] == 7'd0);
    assign btn_ok_c      = (rx_data[7:3] == 5'd0);
    assign resync_c      = is_sync_c ? ST_XL : ST_HUNT;
    assign timeout_hit_c = (state_q != ST_HUNT) && (cnt_q <= CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: rx_error beats an accepted byte, which beats the timeout.
    always_comb begin
        state_d = state_q;
        if (rx_error) begin
            state_d = ST_HUNT;
        end else if (accept_c) begin
            case (state_q)
                ST_HUNT: state_d = is_sync_c ? ST_XL : ST_HUNT;
                ST_XL:   state_d = ST_XH;
                ST_XH:   state_d = hi_ok_c ? ST_YL : resync_c;
                ST_YL:   state_d = ST_YH;
                ST_YH:   state_d = hi_ok_c ? ST_BTN : resync_c;
                ST_BTN:  state_d = btn_ok_c ? ST_HUNT : resync_c;
                default: state_d = ST_HUNT;
            endcase
        end else if (timeout_hit_c) begin
            state_d = ST_HUNT;
        end
    end

    // Output and datapath next values: captures, commit, pulses, counters.
    always_comb begin
        rx_ack_d        = accept_c;
        cnt_d           = cnt_q;
        xl_d            = xl_q;
        xh_d            = xh_q;
        yl_d            = yl_q;
        yh_d            = yh_q;
        mouse_x_d       = mouse_x_q;
        mouse_y_d       = mouse_y_q;
        buttons_d       = buttons_q;
        packet_valid_d  = 1'b0;
        sync_error_d    = 1'b0;
        format_error_d  = 1'b0;
        timeout_error_d = 1'b0;
        err_inc         = 1'b0;

        if (accept_c) begin
            cnt_d = TIMEOUT_LOAD;
        end else if ((state_q != ST_HUNT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (rx_error) begin
            err_inc = 1'b1;
        end else if (accept_c) begin
            case (state_q)
                ST_HUNT: sync_error_d = !is_sync_c;
                ST_XL:   xl_d = rx_data;
                ST_XH: begin
                    if (hi_ok_c) begin
                        xh_d = rx_data[0];
                    end else begin
                        format_error_d = 1'b1;
                        err_inc        = 1'b1;
                    end
                end
                ST_YL:   yl_d = rx_data;
                ST_YH: begin
                    if (hi_ok_c) begin
                        yh_d = rx_data[0];
                    end else begin
                        format_error_d = 1'b1;
                        err_inc        = 1'b1;
                    end
                end
                ST_BTN: begin
                    if (btn_ok_c) begin
                        mouse_x_d      = {xh_q, xl_q};
                        mouse_y_d      = {yh_q, yl_q};
                        buttons_d      = rx_data[2:0];
                        packet_valid_d = 1'b1;
                    end else begin
                        format_error_d = 1'b1;
                        err_inc        = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (timeout_hit_c) begin
            timeout_error_d = 1'b1;
            err_inc         = 1'b1;
        end

        err_count_d = (err_inc && (err_count_q != ERR_MAX)) ? err_count_q + 8'd1 : err_count_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ack_q        <= 1'b0;
            cnt_q           <= '0;
            xl_q            <= 8'd0;
            xh_q            <= 1'b0;
            yl_q            <= 8'd0;
            yh_q            <= 1'b0;
            mouse_x_q       <= 9'd0;
            mouse_y_q       <= 9'd0;
            buttons_q       <= 3'd0;
            packet_valid_q  <= 1'b0;
            sync_error_q    <= 1'b0;
            format_error_q  <= 1'b0;
            timeout_error_q <= 1'b0;
            err_count_q     <= 8'd0;
        end else begin
            rx_ack_q        <= rx_ack_d;
            cnt_q           <= cnt_d;
            xl_q            <= xl_d;
            xh_q            <= xh_d;
            yl_q            <= yl_d;
            yh_q            <= yh_d;
            mouse_x_q       <= mouse_x_d;
            mouse_y_q       <= mouse_y_d;
            buttons_q       <= buttons_d;
            packet_valid_q  <= packet_valid_d;
            sync_error_q    <= sync_error_d;
            format_error_q  <= format_error_d;
            timeout_error_q <= timeout_error_d;
            err_count_q     <= err_count_d;
        end
    end

    assign rx_ack        = rx_ack_q;
    assign mouse_x       = mouse_x_q;
    assign mouse_y       = mouse_y_q;
    assign buttons       = buttons_q;
    assign packet_valid  = packet_valid_q;
    assign sync_error    = sync_error_q;
    assign format_error  = format_error_q;
    assign timeout_error = timeout_error_q;
    assign err_count     = err_count_q;

endmodule
